branch_target_unit: RTL and testbench
=====================================

Name: branch_target_unit

Overview:
- Parametrised, pipelined successor to the OTTER combinational branch address generator.
- Accepts one control-flow request per cycle over a valid/ready handshake and computes the target for SEQ, JAL, JALR or BRANCH.
- Presents the target one cycle later in a registered output stage.
- Maintains a return-address stack (RAS) so fetch gets a predicted return target; sits between decode and the PC mux.

Parameters:
- XLEN, 32, datapath/address width in bits.
- RAS_DEPTH, 4, RAS entries (power of two, >=2).
- PTR_W, $clog2(RAS_DEPTH), RAS pointer width (derived, not overridden).

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- flush  in  1  synchronous flush: drops the output stage and empties the RAS.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when req_valid && req_ready.
- req_op  in  2  0=SEQ, 1=JAL, 2=JALR, 3=BRANCH.
- req_push  in  1  push pc+4 on the RAS (call).
- req_pop  in  1  pop the RAS (return).
- pc  in  XLEN  address of the requesting instruction.
- rs1  in  XLEN  JALR base.
- imm_i, imm_b, imm_j  in  XLEN  sign-extended immediates.
- tgt_valid  out  1  output stage holds a result.
- tgt_ready  in  1  consumer takes the result.
- tgt_addr  out  XLEN  computed target.
- tgt_link  out  XLEN  pc+4 of the request.
- tgt_misalign  out  1  target not 4-byte aligned.
- pred_addr  out  XLEN  RAS top captured at accept (pre-pop value).
- pred_valid  out  1  RAS was non-empty when the pop was accepted.

Behaviour:
- Reset (RST_N low, async):
  - tgt_valid=0; tgt_addr, tgt_link and pred_addr = 0; tgt_misalign=0; pred_valid=0.
  - RAS pointer=0, count=0, all entries 0.
- Handshake:
  - req_ready = !tgt_valid || tgt_ready (combinational, single-entry pipe, full throughput).
  - Output holds stable while tgt_valid && !tgt_ready.
  - Latency: exactly 1 cycle from accept to tgt_valid.
- Arithmetic, all mod 2^XLEN with no overflow flag:
  - SEQ: pc+4.
  - JAL: pc+imm_j.
  - BRANCH: pc+imm_b.
  - JALR: (rs1+imm_i) with bit0 cleared.
  - tgt_link = pc+4 for every op.
- RAS, updated only on accept:
  - Pop: count>0 gives pred_valid=1, pred_addr=top, count-1. count==0 gives pred_valid=0, pred_addr=0, count stays 0 and the pointer is unchanged.
  - Push: write pc+4 at pointer+1 (wraps mod RAS_DEPTH). count saturates at RAS_DEPTH; on overflow the oldest entry is silently overwritten.
  - Push and pop together (coroutine): pred_addr = old top; top is replaced by pc+4; count unchanged (when count==0, count becomes 1).
  - pred_valid and pred_addr are meaningful only when req_pop was set; otherwise pred_valid=0.
- flush:
  - Next edge: tgt_valid=0, RAS count=0, pointer=0.
  - Any request accepted in the same cycle is discarded.
  - flush has priority over accept and over tgt_ready.
- Reset mid-transfer: result and RAS are lost immediately; req_ready is 1 after reset.

Optional Feature:
- BTU_MISALIGN_CHECK_EN
  - Defined: tgt_misalign = (tgt_addr[1:0] != 0), registered with the result.
  - Undefined: tgt_misalign is tied to 0 and no compare logic is built.

Decomposition:
- Package otter_btu_pkg holds:
  - btu_op_e enum (SEQ, JAL, JALR, BRANCH);
  - localparam INSTR_BYTES=4;
  - the JALR LSB mask constant.
- One sub-module: ras_stack (parametrised circular stack with push, pop, count, top, empty, full), instantiated once.

Test Plan:
- JAL, pc=0x100, imm_j=0x20, tgt_ready=1 -> one cycle later tgt_valid=1, tgt_addr=0x120, tgt_link=0x104, tgt_misalign=0.
- JALR, rs1=0x2001, imm_i=0x4 -> tgt_addr=0x2004. With macro, rs1=0x2002 -> tgt_addr=0x2006, tgt_misalign=1; without macro, tgt_misalign=0.
- BRANCH, pc=0x4, imm_b=0xFFFFFFF8 -> tgt_addr=0xFFFFFFFC (wrap). Hold tgt_ready=0 for 3 cycles -> req_ready=0 and outputs stable, then the result drains.
- Push 5 calls from pc=0x10,0x20,0x30,0x40,0x50 (RAS_DEPTH=4), then 5 pops -> pred_addr = 0x54, 0x44, 0x34, 0x24 with pred_valid=1, then the 5th pop gives pred_valid=0, pred_addr=0.
- Push+pop together with top=0x44 and pc=0x80 -> pred_addr=0x44, new top=0x84, count unchanged.
- flush asserted alongside req_valid while tgt_valid=1 -> next cycle tgt_valid=0, RAS empty, and a following pop gives pred_valid=0. Assert RST_N=0 mid-stall -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/otter_btu_pkg.sv
// Shared types and constants for the branch target unit.
// Optional build macro used elsewhere: BTU_MISALIGN_CHECK_EN.
package otter_btu_pkg;

   // Control-flow operation carried by each request
   typedef enum logic [1:0] {
      SEQ    = 2'd0,
      JAL    = 2'd1,
      JALR   = 2'd2,
      BRANCH = 2'd3
   } btu_op_e;

   // Size of one instruction; the link address is pc plus this
   localparam int INSTR_BYTES = 4;

   // JALR clears bit 0 of the computed target; sliced to XLEN by users
   localparam logic [63:0] JALR_LSB_MASK = ~64'd1;

endpackage

// File: rtl/branch_target_unit_ras_stack.sv
// Circular return-address stack. ptr_r always indexes the current top entry;
// a push writes one slot above it, so overflow silently overwrites the oldest
// entry while count saturates at DEPTH. clr empties the stack and takes
// priority over push/pop.
module ras_stack #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             push,
   input  logic             pop,
   input  logic [XLEN-1:0]  push_data,
   output logic [XLEN-1:0]  top,
   output logic [PTR_W:0]   count,
   output logic             empty,
   output logic             full
);

   logic [XLEN-1:0]  mem_r [DEPTH];
   logic [PTR_W-1:0] ptr_r;
   logic [PTR_W:0]   count_r;

   logic [PTR_W-1:0] ptr_nxt_s;
   logic [PTR_W:0]   count_nxt_s;
   logic             wr_en_s;
   logic [PTR_W-1:0] wr_idx_s;

   assign top   = mem_r[ptr_r];
   assign count = count_r;
   assign empty = (count_r == {(PTR_W+1){1'b0}});
   assign full  = (count_r == (PTR_W+1)'(DEPTH));

   // Next pointer/count and write slot for the requested stack operation
   always_comb begin
      ptr_nxt_s   = ptr_r;
      count_nxt_s = count_r;
      wr_en_s     = 1'b0;
      wr_idx_s    = ptr_r;
      if (clr) begin
         ptr_nxt_s   = {PTR_W{1'b0}};
         count_nxt_s = {(PTR_W+1){1'b0}};
      end else if (push && pop) begin
         // coroutine swap: replace the top in place
         wr_en_s  = 1'b1;
         wr_idx_s = ptr_r;
         if (empty) begin
            count_nxt_s = (PTR_W+1)'(1);
         end else begin
            count_nxt_s = count_r;
         end
      end else if (push) begin
         wr_en_s   = 1'b1;
         wr_idx_s  = ptr_r + PTR_W'(1);
         ptr_nxt_s = ptr_r + PTR_W'(1);
         if (full) begin
            count_nxt_s = count_r;
         end else begin
            count_nxt_s = count_r + (PTR_W+1)'(1);
         end
      end else if (pop && !empty) begin
         ptr_nxt_s   = ptr_r - PTR_W'(1);
         count_nxt_s = count_r - (PTR_W+1)'(1);
      end else begin
         ptr_nxt_s   = ptr_r;
         count_nxt_s = count_r;
      end
   end

   // Stack pointer, occupancy and entry storage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_r   <= {PTR_W{1'b0}};
         count_r <= {(PTR_W+1){1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {XLEN{1'b0}};
         end
      end else begin
         ptr_r   <= ptr_nxt_s;
         count_r <= count_nxt_s;
         if (wr_en_s) begin
            mem_r[wr_idx_s] <= push_data;
         end
      end
   end

endmodule

// File: rtl/branch_target_unit.sv
// Pipelined branch target unit: one request per cycle in, registered target
// one cycle later, plus a return-address stack prediction for fetch.
// Build macro BTU_MISALIGN_CHECK_EN adds the registered 4-byte alignment flag;
// without it tgt_misalign is constant 0.
module branch_target_unit
   import otter_btu_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int RAS_DEPTH = 4
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             flush,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_op,
   input  logic             req_push,
   input  logic             req_pop,
   input  logic [XLEN-1:0]  pc,
   input  logic [XLEN-1:0]  rs1,
   input  logic [XLEN-1:0]  imm_i,
   input  logic [XLEN-1:0]  imm_b,
   input  logic [XLEN-1:0]  imm_j,
   output logic             tgt_valid,
   input  logic             tgt_ready,
   output logic [XLEN-1:0]  tgt_addr,
   output logic [XLEN-1:0]  tgt_link,
   output logic             tgt_misalign,
   output logic [XLEN-1:0]  pred_addr,
   output logic             pred_valid
);

   localparam int PTR_W = $clog2(RAS_DEPTH);

   logic             tgt_valid_r;
   logic [XLEN-1:0]  tgt_addr_r;
   logic [XLEN-1:0]  tgt_link_r;
   logic [XLEN-1:0]  pred_addr_r;
   logic             pred_valid_r;

   logic             accept_s;
   logic [XLEN-1:0]  link_s;
   logic [XLEN-1:0]  target_s;
   logic [XLEN-1:0]  ras_top_s;
   logic             ras_empty_s;
   logic [PTR_W:0]   ras_count_unused_s;
   logic             ras_full_unused_s;

   assign req_ready = !tgt_valid_r || tgt_ready;
   assign accept_s  = req_valid && req_ready;

   assign tgt_valid  = tgt_valid_r;
   assign tgt_addr   = tgt_addr_r;
   assign tgt_link   = tgt_link_r;
   assign pred_addr  = pred_addr_r;
   assign pred_valid = pred_valid_r;

   // Target and link address for the incoming request (all mod 2^XLEN)
   always_comb begin
      link_s   = pc + XLEN'(INSTR_BYTES);
      target_s = link_s;
      case (btu_op_e'(req_op))
         SEQ:     target_s = link_s;
         JAL:     target_s = pc + imm_j;
         JALR:    target_s = (rs1 + imm_i) & JALR_LSB_MASK[XLEN-1:0];
         BRANCH:  target_s = pc + imm_b;
         default: target_s = link_s;
      endcase
   end

   ras_stack #(
      .XLEN  (XLEN),
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (CLK),
      .rst_n     (RST_N),
      .clr       (flush),
      .push      (accept_s && req_push),
      .pop       (accept_s && req_pop),
      .push_data (link_s),
      .top       (ras_top_s),
      .count     (ras_count_unused_s),
      .empty     (ras_empty_s),
      .full      (ras_full_unused_s)
   );

   // Output stage: flush drops it, accept loads it, consumer drains it
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         tgt_valid_r  <= 1'b0;
         tgt_addr_r   <= {XLEN{1'b0}};
         tgt_link_r   <= {XLEN{1'b0}};
         pred_addr_r  <= {XLEN{1'b0}};
         pred_valid_r <= 1'b0;
      end else if (flush) begin
         tgt_valid_r  <= 1'b0;
      end else if (accept_s) begin
         tgt_valid_r  <= 1'b1;
         tgt_addr_r   <= target_s;
         tgt_link_r   <= link_s;
         pred_valid_r <= req_pop && !ras_empty_s;
         pred_addr_r  <= (req_pop && !ras_empty_s) ? ras_top_s : {XLEN{1'b0}};
      end else if (tgt_ready) begin
         tgt_valid_r  <= 1'b0;
      end
   end

`ifdef BTU_MISALIGN_CHECK_EN
   logic misalign_r;

   // Alignment flag captured alongside the target
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         misalign_r <= 1'b0;
      end else if (!flush && accept_s) begin
         misalign_r <= (target_s[1:0] != 2'b00);
      end
   end

   assign tgt_misalign = misalign_r;
`else
   assign tgt_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_branch_target_unit.sv
// Directed self-checking bench for branch_target_unit (XLEN=32, RAS_DEPTH=4).
module tb_branch_target_unit;

   logic        CLK;
   logic        RST_N;
   logic        flush;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic        req_push;
   logic        req_pop;
   logic [31:0] pc;
   logic [31:0] rs1;
   logic [31:0] imm_i;
   logic [31:0] imm_b;
   logic [31:0] imm_j;
   logic        tgt_valid;
   logic        tgt_ready;
   logic [31:0] tgt_addr;
   logic [31:0] tgt_link;
   logic        tgt_misalign;
   logic [31:0] pred_addr;
   logic        pred_valid;

   int checks;
   int failures;

`ifdef BTU_MISALIGN_CHECK_EN
   localparam logic MIS_EXP = 1'b1;
`else
   localparam logic MIS_EXP = 1'b0;
`endif

   branch_target_unit #(.XLEN(32), .RAS_DEPTH(4)) dut (
      .CLK          (CLK),
      .RST_N        (RST_N),
      .flush        (flush),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_op       (req_op),
      .req_push     (req_push),
      .req_pop      (req_pop),
      .pc           (pc),
      .rs1          (rs1),
      .imm_i        (imm_i),
      .imm_b        (imm_b),
      .imm_j        (imm_j),
      .tgt_valid    (tgt_valid),
      .tgt_ready    (tgt_ready),
      .tgt_addr     (tgt_addr),
      .tgt_link     (tgt_link),
      .tgt_misalign (tgt_misalign),
      .pred_addr    (pred_addr),
      .pred_valid   (pred_valid)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Advance one clock edge and settle
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Present one request (held until changed)
   task automatic drive(input logic [1:0] op, input logic [31:0] p,
                        input logic psh, input logic pp);
      req_valid = 1'b1;
      req_op    = op;
      pc        = p;
      req_push  = psh;
      req_pop   = pp;
   endtask

   task automatic idle();
      req_valid = 1'b0;
      req_push  = 1'b0;
      req_pop   = 1'b0;
   endtask

   task automatic test_reset();
      RST_N = 1'b0; flush = 1'b0; tgt_ready = 1'b1; idle();
      req_op = 2'd0; pc = 32'h0; rs1 = 32'h0;
      imm_i = 32'h0; imm_b = 32'h0; imm_j = 32'h0;
      #1;
      checks++;
      if ({tgt_valid, tgt_addr, tgt_link, tgt_misalign, pred_addr, pred_valid} !== 99'd0) begin
         failures++;
         $display("FAIL reset_outputs got v=%b a=%h l=%h m=%b p=%h pv=%b exp all 0",
                  tgt_valid, tgt_addr, tgt_link, tgt_misalign, pred_addr, pred_valid);
      end
      checks++;
      if (req_ready !== 1'b1) begin
         failures++; $display("FAIL reset_ready got=%b exp=1", req_ready);
      end
      step(); step();
      RST_N = 1'b1;
      step();
   endtask

   task automatic test_jal();
      imm_j = 32'h20;
      drive(2'd1, 32'h100, 1'b0, 1'b0);
      step();
      idle();
      checks++;
      if ({tgt_valid, tgt_addr, tgt_link, tgt_misalign} !== {1'b1, 32'h120, 32'h104, 1'b0}) begin
         failures++;
         $display("FAIL jal got v=%b a=%h l=%h m=%b exp v=1 a=120 l=104 m=0",
                  tgt_valid, tgt_addr, tgt_link, tgt_misalign);
      end
      checks++;
      if (pred_valid !== 1'b0) begin
         failures++; $display("FAIL jal_pred_valid got=%b exp=0", pred_valid);
      end
      step();
      checks++;
      if (tgt_valid !== 1'b0) begin
         failures++; $display("FAIL jal_drain got=%b exp=0", tgt_valid);
      end
   endtask

   task automatic test_jalr();
      rs1 = 32'h2001; imm_i = 32'h4;
      drive(2'd2, 32'h500, 1'b0, 1'b0);
      step();
      checks++;
      if ({tgt_addr, tgt_link, tgt_misalign} !== {32'h2004, 32'h504, 1'b0}) begin
         failures++;
         $display("FAIL jalr_lsb got a=%h l=%h m=%b exp a=2004 l=504 m=0",
                  tgt_addr, tgt_link, tgt_misalign);
      end
      rs1 = 32'h2002;
      step();
      idle();
      checks++;
      if (tgt_addr !== 32'h2006) begin
         failures++; $display("FAIL jalr_mis_addr got=%h exp=2006", tgt_addr);
      end
      checks++;
      if (tgt_misalign !== MIS_EXP) begin
         failures++; $display("FAIL jalr_misalign got=%b exp=%b", tgt_misalign, MIS_EXP);
      end
      step();
   endtask

   task automatic test_stall();
      imm_b = 32'hFFFF_FFF8;
      drive(2'd3, 32'h4, 1'b0, 1'b0);
      step();
      checks++;
      if ({tgt_valid, tgt_addr, tgt_misalign} !== {1'b1, 32'hFFFF_FFFC, 1'b0}) begin
         failures++;
         $display("FAIL branch_wrap got v=%b a=%h m=%b exp v=1 a=fffffffc m=0",
                  tgt_valid, tgt_addr, tgt_misalign);
      end
      tgt_ready = 1'b0;
      drive(2'd0, 32'h200, 1'b0, 1'b0);
      #1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (req_ready !== 1'b0) begin
            failures++; $display("FAIL stall_ready cycle=%0d got=%b exp=0", i, req_ready);
         end
         step();
         checks++;
         if ({tgt_valid, tgt_addr, tgt_link} !== {1'b1, 32'hFFFF_FFFC, 32'h8}) begin
            failures++;
            $display("FAIL stall_hold cycle=%0d got v=%b a=%h l=%h exp v=1 a=fffffffc l=8",
                     i, tgt_valid, tgt_addr, tgt_link);
         end
      end
      tgt_ready = 1'b1;
      #1;
      checks++;
      if (req_ready !== 1'b1) begin
         failures++; $display("FAIL unstall_ready got=%b exp=1", req_ready);
      end
      step();
      idle();
      checks++;
      if ({tgt_valid, tgt_addr} !== {1'b1, 32'h204}) begin
         failures++;
         $display("FAIL back_to_back got v=%b a=%h exp v=1 a=204", tgt_valid, tgt_addr);
      end
      step();
      checks++;
      if (tgt_valid !== 1'b0) begin
         failures++; $display("FAIL stall_drain got=%b exp=0", tgt_valid);
      end
   endtask

   task automatic test_ras();
      logic [31:0] exp_pred [5];
      logic        exp_pv   [5];
      exp_pred[0] = 32'h54; exp_pred[1] = 32'h44; exp_pred[2] = 32'h34;
      exp_pred[3] = 32'h24; exp_pred[4] = 32'h0;
      exp_pv[0] = 1'b1; exp_pv[1] = 1'b1; exp_pv[2] = 1'b1;
      exp_pv[3] = 1'b1; exp_pv[4] = 1'b0;
      imm_j = 32'h100;
      for (int i = 0; i < 5; i++) begin
         drive(2'd1, 32'h10 * (i + 1), 1'b1, 1'b0);
         step();
      end
      rs1 = 32'h0; imm_i = 32'h0;
      for (int i = 0; i < 5; i++) begin
         drive(2'd2, 32'h900, 1'b0, 1'b1);
         step();
         checks++;
         if ({pred_valid, pred_addr} !== {exp_pv[i], exp_pred[i]}) begin
            failures++;
            $display("FAIL ras_pop%0d got pv=%b pa=%h exp pv=%b pa=%h",
                     i, pred_valid, pred_addr, exp_pv[i], exp_pred[i]);
         end
      end
      idle();
      step();
   endtask

   task automatic test_coroutine();
      drive(2'd1, 32'h40, 1'b1, 1'b0);
      step();
      drive(2'd2, 32'h80, 1'b1, 1'b1);
      step();
      checks++;
      if ({pred_valid, pred_addr, tgt_link} !== {1'b1, 32'h44, 32'h84}) begin
         failures++;
         $display("FAIL coroutine got pv=%b pa=%h l=%h exp pv=1 pa=44 l=84",
                  pred_valid, pred_addr, tgt_link);
      end
      drive(2'd2, 32'h900, 1'b0, 1'b1);
      step();
      checks++;
      if ({pred_valid, pred_addr} !== {1'b1, 32'h84}) begin
         failures++;
         $display("FAIL coroutine_top got pv=%b pa=%h exp pv=1 pa=84", pred_valid, pred_addr);
      end
      step();
      checks++;
      if ({pred_valid, pred_addr} !== {1'b0, 32'h0}) begin
         failures++;
         $display("FAIL coroutine_count got pv=%b pa=%h exp pv=0 pa=0", pred_valid, pred_addr);
      end
      idle();
      step();
   endtask

   task automatic test_flush();
      drive(2'd1, 32'h60, 1'b1, 1'b0);
      step();
      drive(2'd2, 32'h70, 1'b0, 1'b1);
      flush = 1'b1;
      step();
      flush = 1'b0;
      checks++;
      if (tgt_valid !== 1'b0) begin
         failures++; $display("FAIL flush_valid got=%b exp=0", tgt_valid);
      end
      step();
      idle();
      checks++;
      if ({tgt_valid, pred_valid, pred_addr} !== {1'b1, 1'b0, 32'h0}) begin
         failures++;
         $display("FAIL flush_ras got v=%b pv=%b pa=%h exp v=1 pv=0 pa=0",
                  tgt_valid, pred_valid, pred_addr);
      end
      step();
   endtask

   task automatic test_async_reset();
      imm_j = 32'h10;
      tgt_ready = 1'b0;
      drive(2'd1, 32'h300, 1'b1, 1'b0);
      step();
      idle();
      step();
      checks++;
      if ({tgt_valid, tgt_addr} !== {1'b1, 32'h310}) begin
         failures++;
         $display("FAIL pre_reset got v=%b a=%h exp v=1 a=310", tgt_valid, tgt_addr);
      end
      #2;
      RST_N = 1'b0;
      #1;
      checks++;
      if ({tgt_valid, tgt_addr, tgt_link, tgt_misalign, pred_addr, pred_valid} !== 99'd0) begin
         failures++;
         $display("FAIL async_reset got v=%b a=%h l=%h m=%b p=%h pv=%b exp all 0",
                  tgt_valid, tgt_addr, tgt_link, tgt_misalign, pred_addr, pred_valid);
      end
      checks++;
      if (req_ready !== 1'b1) begin
         failures++; $display("FAIL async_reset_ready got=%b exp=1", req_ready);
      end
      #1;
      RST_N = 1'b1;
      tgt_ready = 1'b1;
      drive(2'd2, 32'h900, 1'b0, 1'b1);
      step();
      idle();
      checks++;
      if ({tgt_valid, pred_valid, pred_addr} !== {1'b1, 1'b0, 32'h0}) begin
         failures++;
         $display("FAIL reset_ras got v=%b pv=%b pa=%h exp v=1 pv=0 pa=0",
                  tgt_valid, pred_valid, pred_addr);
      end
      step();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_jal();
      test_jalr();
      test_stall();
      test_ras();
      test_coroutine();
      test_flush();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
